// File: rtl/rf_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_access_arbiter_if
// Purpose : Bundles the requester-side signals of the register-file access
//           arbiter: the writeback request, the operand-read request and the
//           read response.
// Modports:
//   master : requester side (drives requests, receives ready and response)
//   slave  : arbiter side  (receives requests, drives ready and response)
// Signals :
//   wr_valid/wr_ready/wr_rd/wr_data           writeback handshake and payload
//   rd_valid/rd_ready/rd_rs1/rd_rs2           operand-read handshake and addresses
//   rsp_valid/rsp_out1/rsp_out2               read response, one cycle after grant
// -----------------------------------------------------------------------------
interface rf_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_rs1;
  logic [ADDR_W-1:0] rd_rs2;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_out1;
  logic [DATA_W-1:0] rsp_out2;

  modport master (
    output wr_valid, wr_rd, wr_data, rd_valid, rd_rs1, rd_rs2,
    input  wr_ready, rd_ready, rsp_valid, rsp_out1, rsp_out2
  );

  modport slave (
    input  wr_valid, wr_rd, wr_data, rd_valid, rd_rs1, rd_rs2,
    output wr_ready, rd_ready, rsp_valid, rsp_out1, rsp_out2
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// -----------------------------------------------------------------------------
// rf_access_arbiter
// Purpose : Shares a single-port register file (one write or one dual read per
//           clock) between a writeback requester and an operand-read requester.
//           Writes win contention, but after MAX_WR_STREAK consecutive contended
//           write grants a pending read is forced through. Read data returns one
//           cycle after the grant.
// Ports   :
//   clk, rst                 clock, synchronous active-high reset
//   bus (slave modport)      request/ready/response signals
//   rf_write                 file write strobe (0 = file performs a read)
//   rf_write_data, rf_rd     write data / destination register to the file
//   rf_rs1, rf_rs2           read addresses to the file
//   rf_out1, rf_out2         file read data, valid the cycle after a read cycle
// -----------------------------------------------------------------------------
module rf_access_arbiter #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int MAX_WR_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  rf_access_arbiter_if.slave bus,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  output logic [ADDR_W-1:0] rf_rd,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2
);

  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);

  typedef enum logic {
    WR_PRI = 1'b0,
    RD_PRI = 1'b1
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_inc;
  logic          rsp_valid_q;
  logic          wr_real;
  logic          contention;
  logic          wr_grant;
  logic          rd_grant;

  // Grant decision: writes to x0 never occupy the file port, so they are
  // acknowledged at once and never count as contention.
  always_comb begin
    wr_real    = bus.wr_valid && (bus.wr_rd != {ADDR_W{1'b0}});
    contention = bus.rd_valid && wr_real;
    wr_grant   = 1'b0;
    rd_grant   = 1'b0;
    if (rst) begin
      wr_grant = 1'b0;
      rd_grant = 1'b0;
    end else if (contention) begin
      if (state == RD_PRI) begin
        rd_grant = 1'b1;
      end else begin
        wr_grant = 1'b1;
      end
    end else begin
      wr_grant = bus.wr_valid;
      rd_grant = bus.rd_valid;
    end
  end

  // Saturating increment of the contended-write streak.
  always_comb begin
    if (streak == STREAK_MAX) begin
      streak_inc = streak;
    end else begin
      streak_inc = streak + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  // Priority FSM, streak counter and response-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WR_PRI;
      streak      <= {SW{1'b0}};
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= rd_grant;
      if (rd_grant || !bus.rd_valid) begin
        // A served or withdrawn read ends any starvation episode.
        state  <= WR_PRI;
        streak <= {SW{1'b0}};
      end else if (contention && wr_grant) begin
        streak <= streak_inc;
        if (streak_inc == STREAK_MAX) begin
          state <= RD_PRI;
        end else begin
          state <= state;
        end
      end else begin
        state  <= state;
        streak <= streak;
      end
    end
  end

  assign bus.wr_ready  = wr_grant;
  assign bus.rd_ready  = rd_grant;
  // A response whose grant preceded reset is dropped while reset is high.
  assign bus.rsp_valid = rsp_valid_q && !rst;
  assign bus.rsp_out1  = rf_out1;
  assign bus.rsp_out2  = rf_out2;

  assign rf_write      = wr_grant && wr_real;
  assign rf_write_data = bus.wr_data;
  assign rf_rd         = bus.wr_rd;
  assign rf_rs1        = bus.rd_rs1;
  assign rf_rs2        = bus.rd_rs2;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_access_arbiter
// Purpose : Directed self-checking bench for rf_access_arbiter with a
//           behavioural register file and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_rf_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_write;
  logic [31:0] rf_write_data;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_out1, rf_out2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          at;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;
  exp_t exp_q[$];

  rf_access_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_access_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WR_STREAK(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_write(rf_write), .rf_write_data(rf_write_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  always #5 clk = ~clk;

  // cycle counter used to time-stamp expected responses
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural single-port register file; x_i starts as 0x1000_0000+i, x0 = 0
  logic [31:0] mem [32];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'h0 : (32'h1000_0000 + 32'(i));
      mem_init <= 1'b1;
    end else if (rf_write) begin
      mem[rf_rd] <= rf_write_data;
    end else begin
      rf_out1 <= mem[rf_rs1];
      rf_out2 <= mem[rf_rs2];
    end
  end

  // monitor: pops one expected entry per response pulse
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_spurious: got rsp_valid=1 at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.at != cyc || bus.rsp_out1 !== e.d1 || bus.rsp_out2 !== e.d2) begin
          fails++;
          $display("FAIL rsp_data: got cyc=%0d out1=%h out2=%h, required cyc=%0d out1=%h out2=%h",
                   cyc, bus.rsp_out1, bus.rsp_out2, e.at, e.d1, e.d2);
        end
      end
    end
  end

  // one stimulus cycle; exp_g = {wr_ready, rd_ready, rf_write}
  task automatic step(input logic r, input logic wv, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic rv, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] exp_g, input logic push,
                      input logic [31:0] e1, input logic [31:0] e2, input string name);
    logic [2:0] got;
    exp_t       e;
    @(posedge clk);
    #1;
    rst = r;
    bus.wr_valid = wv; bus.wr_rd = wrd; bus.wr_data = wd;
    bus.rd_valid = rv; bus.rd_rs1 = s1; bus.rd_rs2 = s2;
    if (push) begin
      e.at = cyc + 1; e.d1 = e1; e.d2 = e2;
      exp_q.push_back(e);
    end
    @(negedge clk);
    got = {bus.wr_ready, bus.rd_ready, rf_write};
    tests++;
    if (got !== exp_g) begin
      fails++;
      $display("FAIL %s: got {wr_ready,rd_ready,rf_write}=%b, required %b", name, got, exp_g);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_rd = 5'd0; bus.wr_data = 32'h0;
    bus.rd_valid = 1'b0; bus.rd_rs1 = 5'd0; bus.rd_rs2 = 5'd0;

    // reset: requests present but nothing granted
    step(1'b1, 1'b1, 5'd5, 32'h1, 1'b1, 5'd1, 5'd2, 3'b000, 1'b0, 32'h0, 32'h0, "reset0");
    step(1'b1, 1'b1, 5'd5, 32'h1, 1'b1, 5'd1, 5'd2, 3'b000, 1'b0, 32'h0, 32'h0, "reset1");
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0, 32'h0, "idle");

    // write then read-after-write
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "wr_x5");
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 3'b010, 1'b1, 32'hDEADBEEF, 32'h0, "rd_x5");

    // sustained contention: W,W,W,R,W,W
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd1, 3'b101, 1'b0, 32'h0, 32'h0, "cont_w1");
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd1, 3'b101, 1'b0, 32'h0, 32'h0, "cont_w2");
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd1, 3'b101, 1'b0, 32'h0, 32'h0, "cont_w3");
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd1, 3'b010, 1'b1, 32'h77, 32'h1000_0001, "cont_r4");
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd1, 3'b101, 1'b0, 32'h0, 32'h0, "cont_w5");
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd1, 3'b101, 1'b0, 32'h0, 32'h0, "cont_w6");
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0, 32'h0, "idle2");

    // write to x0 alongside a read: both granted, no file write
    step(1'b0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd3, 5'd7, 3'b110, 1'b1, 32'h1000_0003, 32'h77, "x0_wr_rd");

    // ordering: read x9 then write x9 -> old value; read again -> new value
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 3'b010, 1'b1, 32'h1000_0009, 32'h0, "rd_x9_old");
    step(1'b0, 1'b1, 5'd9, 32'hA5, 1'b0, 5'd0, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "wr_x9");
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 3'b010, 1'b1, 32'hA5, 32'h0, "rd_x9_new");

    // reset while read-priority is armed: afterwards writes win three times again
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "pre_w1");
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "pre_w2");
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "pre_w3");
    step(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd0, 3'b000, 1'b0, 32'h0, 32'h0, "mid_rst");
    step(1'b0, 1'b1, 5'd4, 32'h45, 1'b1, 5'd4, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "post_w1");
    step(1'b0, 1'b1, 5'd4, 32'h45, 1'b1, 5'd4, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "post_w2");
    step(1'b0, 1'b1, 5'd4, 32'h45, 1'b1, 5'd4, 5'd0, 3'b101, 1'b0, 32'h0, 32'h0, "post_w3");
    step(1'b0, 1'b1, 5'd4, 32'h45, 1'b1, 5'd4, 5'd0, 3'b010, 1'b1, 32'h45, 32'h0, "post_r4");

    // read granted, reset next cycle: response dropped
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd0, 3'b010, 1'b0, 32'h0, 32'h0, "rd_before_rst");
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0, 32'h0, "rst_drop");
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0, 32'h0, "idle3");
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0, 32'h0, "idle4");

    // every expected response must have been consumed
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rsp_missing: got %0d outstanding responses, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
